// File: rtl/pipelined_ripple_adder.sv
// ============================================================================
// pipelined_ripple_adder
//
// Purpose:
//   N-bit unsigned adder computing sum = A + B + cin, split into STAGES equal
//   slices of W = N/STAGES bits. Each stage adds one slice and registers the
//   carry into the next stage, so the critical path is one W-bit add instead
//   of a full N-bit ripple. Inputs and outputs use a valid/ready handshake
//   with full back-pressure; one operand pair is accepted per clock.
//
// Parameters:
//   N       operand width in bits (default 8)
//   STAGES  number of pipeline stages / slices (default 4), must divide N
//
// Ports:
//   clk        in   1     clock, all logic on the rising edge
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     A/B/cin (and sub) valid this cycle
//   in_ready   out  1     block accepts input this cycle
//   A          in   N     operand A, unsigned
//   B          in   N     operand B, unsigned
//   cin        in   1     carry-in
//   sub        in   1     subtract select (only with PIPE_ADDER_SUB_EN)
//   out_valid  out  1     sum valid
//   out_ready  in   1     downstream accepts sum this cycle
//   sum        out  N+1   result, sum[N] = carry-out
//
// Configuration:
//   PIPE_ADDER_SUB_EN  when defined, adds the 'sub' port. sub=1 computes
//                      A - B mod 2^N with sum[N] = 1 meaning no borrow.
//                      Undefined: add only, no 'sub' port.
// ============================================================================
module pipelined_ripple_adder #(
    parameter int N      = 8,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum
);

    localparam int W   = (STAGES > 0) ? N / STAGES : N;
    // Operand registers only exist between stages; keep at least one entry
    // so the single-stage build still has legal array bounds.
    localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;

    if ((STAGES < 1) ? 1'b1 : ((N % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_ripple_adder: STAGES must be >= 1 and divide N");
    end

    // Subtraction is folded in at the entry point: inverting B and forcing
    // the carry-in to 1 turns the adder into A + ~B + 1 = A - B. The inverted
    // operand then travels down the pipeline with the rest of the transaction.
    logic [N-1:0] b_in;
    logic         c_in;

`ifdef PIPE_ADDER_SUB_EN
    assign b_in = sub ? ~B : B;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = B;
    assign c_in = cin;
`endif

    // Pipeline state. Stage k register holds the partial result with slices
    // 0..k filled in, the carry out of slice k, and its valid bit. Operands
    // are shifted right by W after each stage so the next slice to add always
    // sits in the low W bits.
    logic [STAGES-1:0]        v_q;
    logic [STAGES-1:0]        c_q;
    logic [STAGES-1:0][N-1:0] r_q;
    logic [OPS-1:0][N-1:0]    a_q;
    logic [OPS-1:0][N-1:0]    b_q;

    // Per-stage inputs (st_*) and next values (nx_*).
    logic [STAGES-1:0][N-1:0] st_a;
    logic [STAGES-1:0][N-1:0] st_b;
    logic [STAGES-1:0][N-1:0] st_r;
    logic [STAGES-1:0]        st_c;
    logic [STAGES-1:0]        st_v;
    logic [STAGES-1:0][N-1:0] nx_r;
    logic [STAGES-1:0]        nx_c;
    logic [STAGES-1:0][W:0]   slice_s;

    logic stall;

    // A stall happens only when the last stage holds a result nobody takes.
    // With no valid result at the output, out_ready is irrelevant and the
    // pipeline keeps filling.
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[STAGES-1];
    assign sum       = {c_q[STAGES-1], r_q[STAGES-1]};

    // Build each stage's view of its inputs and compute its slice add.
    // Stage 0 takes the ports directly; later stages take the registers of
    // the stage before them.
    always_comb begin
        st_a    = '0;
        st_b    = '0;
        st_r    = '0;
        st_c    = '0;
        st_v    = '0;
        nx_r    = '0;
        nx_c    = '0;
        slice_s = '0;

        st_a[0] = A;
        st_b[0] = b_in;
        st_c[0] = c_in;
        st_v[0] = in_valid;

        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_r[k] = r_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_s[k] = {1'b0, st_a[k][W-1:0]} + {1'b0, st_b[k][W-1:0]}
                       + (W+1)'(st_c[k]);
            nx_r[k]            = st_r[k];
            nx_r[k][k*W +: W]  = slice_s[k][W-1:0];
            nx_c[k]            = slice_s[k][W];
        end
    end

    // All stages advance together unless the output is stalled. Valid bits
    // shift every advancing cycle so bubbles move through like data. The
    // final stage only loads its data when a valid result arrives, which
    // keeps sum holding its last value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            r_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (!stall) begin
            v_q <= st_v;
            for (int k = 0; k < STAGES - 1; k++) begin
                r_q[k] <= nx_r[k];
                c_q[k] <= nx_c[k];
            end
            if (st_v[STAGES-1]) begin
                r_q[STAGES-1] <= nx_r[STAGES-1];
                c_q[STAGES-1] <= nx_c[STAGES-1];
            end
            for (int k = 0; k < OPS; k++) begin
                a_q[k] <= st_a[k] >> W;
                b_q[k] <= st_b[k] >> W;
            end
        end
    end

    // The last stage consumes only the low slice of its operands, and the
    // single-stage build never reads the operand registers.
    logic unused_operands;
    assign unused_operands = ^{st_a[STAGES-1], st_b[STAGES-1], a_q, b_q};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// ============================================================================
// tb_pipelined_ripple_adder
//
// Testbench for pipelined_ripple_adder with N=8, STAGES=4. Covers reset
// state, a table of add vectors streamed back to back, single-pulse
// boundary add, back-pressure, bubbles, reset mid-flight and during a stall,
// subtraction when PIPE_ADDER_SUB_EN is defined, and randomized traffic
// checked against an arithmetic reference model through a FIFO scoreboard.
// ============================================================================
module tb_pipelined_ripple_adder;

    localparam int N      = 8;
    localparam int STAGES = 4;
    localparam int NVEC   = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   sum;
    logic         sub_m;
`ifdef PIPE_ADDER_SUB_EN
    logic         sub;
    assign sub_m = sub;
`else
    assign sub_m = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    bit sb_on        = 1'b0;
    logic [N:0] exp_q[$];

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        logic [N:0]   exp_sum;
    } vec_t;

    vec_t tbl [NVEC];

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    pipelined_ripple_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    // Reference arithmetic: exact N+1 bit add, or A - B mod 2^N with the top
    // bit reporting "no borrow" for subtraction.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c, input logic s);
        logic [N-1:0] diff;
        if (s) begin
            diff = x - y;
            return {(x >= y), diff};
        end
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic c, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
`ifdef PIPE_ADDER_SUB_EN
        sub      = s;
`else
        if (s) begin
            $display("[TB] note: sub requested but PIPE_ADDER_SUB_EN not defined");
        end
`endif
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: at the falling edge, handshake signals are stable for the
    // coming rising edge. Accepted inputs push their expected result; every
    // output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (sb_on && !rst) begin
            checkOutput("sb_in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub_m));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    checkOutput("sb_sum", 32'(sum), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbl[0]  = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tbl[1]  = '{8'h00, 8'h00, 1'b0, 9'h000};
        tbl[2]  = '{8'h00, 8'h00, 1'b1, 9'h001};
        tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        tbl[4]  = '{8'hFF, 8'hFF, 1'b0, 9'h1FE};
        tbl[5]  = '{8'h80, 8'h80, 1'b0, 9'h100};
        tbl[6]  = '{8'h0F, 8'h01, 1'b0, 9'h010};
        tbl[7]  = '{8'hF0, 8'h10, 1'b0, 9'h100};
        tbl[8]  = '{8'h55, 8'hAA, 1'b1, 9'h100};
        tbl[9]  = '{8'hAA, 8'h55, 1'b0, 9'h0FF};
        tbl[10] = '{8'h01, 8'hFE, 1'b1, 9'h100};
        tbl[11] = '{8'h3C, 8'hC3, 1'b0, 9'h0FF};

        // Reset and check the idle state.
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Table vectors back to back; each result exactly STAGES cycles later.
        for (int cyc = 0; cyc < NVEC + STAGES; cyc++) begin
            if (cyc < NVEC) applyStimulus(1'b1, tbl[cyc].a, tbl[cyc].b, tbl[cyc].c, 1'b0);
            else            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            @(negedge clk);
            if (cyc >= STAGES) begin
                checkOutput($sformatf("vec%0d_valid", cyc - STAGES), {31'b0, out_valid}, 32'd1);
                checkOutput($sformatf("vec%0d_sum", cyc - STAGES), 32'(sum),
                            32'(tbl[cyc - STAGES].exp_sum));
            end
            tick();
        end

        // Boundary add as a single pulse.
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc == 0) applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
            else          applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("pulse_valid_c%0d", cyc), {31'b0, out_valid},
                        {31'b0, (cyc == STAGES)});
            if (cyc == STAGES) checkOutput("pulse_sum", 32'(sum), 32'h100);
            tick();
        end

        // Back-pressure: three adds, output stalled five cycles.
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 3) applyStimulus(1'b1, N'(2*cyc + 1), N'(2*cyc + 2), 1'b0, 1'b0);
            else         applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            out_ready = !(cyc >= STAGES && cyc < STAGES + 5);
            @(negedge clk);
            if (cyc >= STAGES && cyc < STAGES + 5) begin
                checkOutput($sformatf("bp_stall_valid_c%0d", cyc), {31'b0, out_valid}, 32'd1);
                checkOutput($sformatf("bp_stall_sum_c%0d", cyc), 32'(sum), 32'd3);
                checkOutput($sformatf("bp_stall_in_ready_c%0d", cyc), {31'b0, in_ready}, 32'd0);
            end else if (cyc >= STAGES + 5 && cyc < STAGES + 8) begin
                checkOutput($sformatf("bp_release_valid_c%0d", cyc), {31'b0, out_valid}, 32'd1);
                checkOutput($sformatf("bp_release_sum_c%0d", cyc), 32'(sum),
                            32'(4 * (cyc - STAGES - 5) + 3));
            end else if (cyc == STAGES + 8) begin
                checkOutput("bp_after_valid", {31'b0, out_valid}, 32'd0);
            end
            tick();
        end
        out_ready = 1'b1;

        // Bubbles: valid, invalid, valid.
        for (int cyc = 0; cyc < 8; cyc++) begin
            case (cyc)
                0:       applyStimulus(1'b1, 8'd10, 8'd1, 1'b0, 1'b0);
                1:       applyStimulus(1'b0, 8'd20, 8'd1, 1'b0, 1'b0);
                2:       applyStimulus(1'b1, 8'd30, 8'd1, 1'b0, 1'b0);
                default: applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            if (cyc >= STAGES) begin
                checkOutput($sformatf("bubble_valid_c%0d", cyc), {31'b0, out_valid},
                            {31'b0, (cyc == STAGES || cyc == STAGES + 2)});
            end
            if (cyc == STAGES || cyc == STAGES + 1) begin
                checkOutput($sformatf("bubble_sum_c%0d", cyc), 32'(sum), 32'd11);
            end
            if (cyc == STAGES + 2) checkOutput("bubble_sum_second", 32'(sum), 32'd31);
            tick();
        end

        // Reset mid-flight: two adds, then reset one cycle later.
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc == 0)      applyStimulus(1'b1, 8'd100, 8'd50, 1'b0, 1'b0);
            else if (cyc == 1) applyStimulus(1'b1, 8'd7, 8'd8, 1'b1, 1'b0);
            else               applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            rst = (cyc == 2);
            @(negedge clk);
            if (cyc >= 3) begin
                checkOutput($sformatf("rst_flight_valid_c%0d", cyc), {31'b0, out_valid}, 32'd0);
                checkOutput($sformatf("rst_flight_sum_c%0d", cyc), 32'(sum), 32'd0);
            end
            tick();
        end

        // Reset during a stall; pipeline fills while out_ready=0 and out_valid=0.
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc == 0) applyStimulus(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
            else          applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            out_ready = 1'b0;
            rst       = (cyc == STAGES + 1);
            @(negedge clk);
            if (cyc == 1) checkOutput("fill_in_ready", {31'b0, in_ready}, 32'd1);
            if (cyc == STAGES) begin
                checkOutput("stall_rst_valid_before", {31'b0, out_valid}, 32'd1);
                checkOutput("stall_rst_sum_before", 32'(sum), 32'd18);
                checkOutput("stall_rst_in_ready_before", {31'b0, in_ready}, 32'd0);
            end
            if (cyc == STAGES + 2) begin
                checkOutput("stall_rst_valid_after", {31'b0, out_valid}, 32'd0);
                checkOutput("stall_rst_in_ready_after", {31'b0, in_ready}, 32'd1);
                checkOutput("stall_rst_sum_after", 32'(sum), 32'd0);
            end
            tick();
        end
        rst       = 1'b0;
        out_ready = 1'b1;

`ifdef PIPE_ADDER_SUB_EN
        // Subtraction: borrow and no-borrow cases; cin is ignored when sub=1.
        for (int cyc = 0; cyc < STAGES + 2; cyc++) begin
            if (cyc == 0)      applyStimulus(1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
            else if (cyc == 1) applyStimulus(1'b1, 8'h07, 8'h05, 1'b1, 1'b1);
            else               applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            @(negedge clk);
            if (cyc == STAGES)     checkOutput("sub_borrow", 32'(sum), 32'h0FE);
            if (cyc == STAGES + 1) checkOutput("sub_no_borrow", 32'(sum), 32'h102);
            tick();
        end
`endif

        // Randomized traffic with random back-pressure against the model.
        sb_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, N'($urandom_range(0, 255)),
                          N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
`ifdef PIPE_ADDER_SUB_EN
                          1'($urandom_range(0, 1)));
`else
                          1'b0);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        sb_on = 1'b0;
        checkOutput("random_drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
